pipe_stage_regs: RTL and testbench

- Pipeline register bank for the five-stage Y86-64 pipeline: F (predicted PC), D, E, M, W stage registers plus the condition-code register.
- Consumes the per-stage stall/bubble/set_CC controls from the pipeline control unit and applies them on each clock edge.
- Stage fields travel as packed buses so the datapath stages connect through a single bundle per boundary.

---
 rtl/pipe_stage_regs.sv | 107 ++++++++++
 tb/tb_pipe_stage_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// Y86-64 pipeline register bank: F predicted PC, D/E/M/W stage registers and
// condition codes, each updated under its own stall/bubble control.
module pipe_stage_regs #(
    parameter int             DW       = 64,
    parameter logic [DW-1:0]  RESET_PC = '0,
    parameter logic [2:0]     RESET_CC = 3'b100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                F_stall,
    input  logic                D_stall,
    input  logic                D_bubble,
    input  logic                E_bubble,
    input  logic                M_bubble,
    input  logic                W_stall,
    input  logic                set_CC,
    input  logic [DW-1:0]       f_predPC,
    output logic [DW-1:0]       F_predPC,
    input  logic [2*DW+18:0]    d_bus,
    output logic [2*DW+18:0]    D_bus,
    input  logic [3*DW+26:0]    e_bus,
    output logic [3*DW+26:0]    E_bus,
    input  logic [2*DW+15:0]    m_bus,
    output logic [2*DW+15:0]    M_bus,
    input  logic [2*DW+14:0]    w_bus,
    output logic [2*DW+14:0]    W_bus,
    input  logic [2:0]          e_cc,
    output logic [2:0]          CC,
    output logic                ctrl_err
);

    localparam logic [2:0]    SAOK  = 3'd1;
    localparam logic [3:0]    INOP  = 4'd1;
    localparam logic [3:0]    FNONE = 4'd0;
    localparam logic [3:0]    RNONE = 4'hF;
    localparam logic [DW-1:0] ZERO  = '0;

    // Bubble images: a NOP with no register writes and zeroed data fields.
    localparam logic [2*DW+18:0] D_BUBBLE = {SAOK, INOP, FNONE, RNONE, RNONE, ZERO, ZERO};
    localparam logic [3*DW+26:0] E_BUBBLE = {SAOK, INOP, FNONE, ZERO, ZERO, ZERO,
                                             RNONE, RNONE, RNONE, RNONE};
    localparam logic [2*DW+15:0] M_BUBBLE = {SAOK, INOP, 1'b0, ZERO, ZERO, RNONE, RNONE};
    localparam logic [2*DW+14:0] W_BUBBLE = {SAOK, INOP, ZERO, ZERO, RNONE, RNONE};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            F_predPC <= f_predPC;
        end
    end

    // Stall outranks bubble in D; the illegal combination is flagged below.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            D_bus <= D_BUBBLE;
        end else if (!D_stall) begin
            if (D_bubble) begin
                D_bus <= D_BUBBLE;
            end else begin
                D_bus <= d_bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || E_bubble) begin
            E_bus <= E_BUBBLE;
        end else begin
            E_bus <= e_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || M_bubble) begin
            M_bus <= M_BUBBLE;
        end else begin
            M_bus <= m_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            W_bus <= W_BUBBLE;
        end else if (!W_stall) begin
            W_bus <= w_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            CC <= RESET_CC;
        end else if (set_CC) begin
            CC <= e_cc;
        end
    end

    // Sticky until reset so a transient control fault is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_err <= 1'b0;
        end else if (D_stall && D_bubble) begin
            ctrl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: directed test-plan steps followed by
// randomized cycles compared against a field-level reference model.
module tb_pipe_stage_regs;

    localparam int DW  = 64;
    localparam int DBW = 2*DW+19;
    localparam int EBW = 3*DW+27;
    localparam int MBW = 2*DW+16;
    localparam int WBW = 2*DW+15;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_CC;
    logic [DW-1:0]  f_predPC, F_predPC;
    logic [DBW-1:0] d_bus, D_bus;
    logic [EBW-1:0] e_bus, E_bus;
    logic [MBW-1:0] m_bus, M_bus;
    logic [WBW-1:0] w_bus, W_bus;
    logic [2:0]     e_cc, CC;
    logic           ctrl_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]  exp_F;
    logic [DBW-1:0] exp_D;
    logic [EBW-1:0] exp_E;
    logic [MBW-1:0] exp_M;
    logic [WBW-1:0] exp_W;
    logic [2:0]     exp_CC;
    logic           exp_err;

    pipe_stage_regs #(.DW(DW), .RESET_PC('0), .RESET_CC(3'b100)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .set_CC(set_CC),
        .f_predPC(f_predPC), .F_predPC(F_predPC),
        .d_bus(d_bus), .D_bus(D_bus), .e_bus(e_bus), .E_bus(E_bus),
        .m_bus(m_bus), .M_bus(M_bus), .w_bus(w_bus), .W_bus(W_bus),
        .e_cc(e_cc), .CC(CC), .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DBW-1:0] mk_d(input logic [2:0] st, input logic [3:0] ic, fn, ra, rb,
                                            input logic [DW-1:0] vc, vp);
        return {st, ic, fn, ra, rb, vc, vp};
    endfunction

    function automatic logic [EBW-1:0] mk_e(input logic [2:0] st, input logic [3:0] ic, fn,
                                            input logic [DW-1:0] vc, va, vb,
                                            input logic [3:0] de, dm, sa, sb);
        return {st, ic, fn, vc, va, vb, de, dm, sa, sb};
    endfunction

    function automatic logic [MBW-1:0] mk_m(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                                            input logic [DW-1:0] ve, va, input logic [3:0] de, dm);
        return {st, ic, cnd, ve, va, de, dm};
    endfunction

    function automatic logic [WBW-1:0] mk_w(input logic [2:0] st, input logic [3:0] ic,
                                            input logic [DW-1:0] ve, vm, input logic [3:0] de, dm);
        return {st, ic, ve, vm, de, dm};
    endfunction

    // Bubble = NOP, status AOK, no register IDs, zero data.
    function automatic logic [DBW-1:0] bub_d();
        return mk_d(3'd1, 4'd1, 4'd0, 4'd15, 4'd15, '0, '0);
    endfunction
    function automatic logic [EBW-1:0] bub_e();
        return mk_e(3'd1, 4'd1, 4'd0, '0, '0, '0, 4'd15, 4'd15, 4'd15, 4'd15);
    endfunction
    function automatic logic [MBW-1:0] bub_m();
        return mk_m(3'd1, 4'd1, 1'b0, '0, '0, 4'd15, 4'd15);
    endfunction
    function automatic logic [WBW-1:0] bub_w();
        return mk_w(3'd1, 4'd1, '0, '0, 4'd15, 4'd15);
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: what each register should hold after the coming edge.
    task automatic model_edge();
        if (!rst_n) begin
            exp_F = '0; exp_D = bub_d(); exp_E = bub_e(); exp_M = bub_m(); exp_W = bub_w();
            exp_CC = 3'b100; exp_err = 1'b0;
        end else begin
            exp_F = F_stall ? exp_F : f_predPC;
            exp_D = D_stall ? exp_D : (D_bubble ? bub_d() : d_bus);
            exp_E = E_bubble ? bub_e() : e_bus;
            exp_M = M_bubble ? bub_m() : m_bus;
            exp_W = W_stall ? exp_W : w_bus;
            exp_CC = set_CC ? e_cc : exp_CC;
            exp_err = exp_err | (D_stall & D_bubble);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".F_predPC"}, 256'(F_predPC), 256'(exp_F));
        chk({tag, ".D_bus"}, 256'(D_bus), 256'(exp_D));
        chk({tag, ".E_bus"}, 256'(E_bus), 256'(exp_E));
        chk({tag, ".M_bus"}, 256'(M_bus), 256'(exp_M));
        chk({tag, ".W_bus"}, 256'(W_bus), 256'(exp_W));
        chk({tag, ".CC"}, 256'(CC), 256'(exp_CC));
        chk({tag, ".ctrl_err"}, 256'(ctrl_err), 256'(exp_err));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_ctrl();
        rst_n = 1'b1; F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        M_bubble = 0; W_stall = 0; set_CC = 0;
    endtask

    task automatic rand_data();
        logic [255:0] r;
        r = rnd256(); d_bus = r[DBW-1:0];
        r = rnd256(); e_bus = r[EBW-1:0];
        r = rnd256(); m_bus = r[MBW-1:0];
        r = rnd256(); w_bus = r[WBW-1:0];
        r = rnd256(); f_predPC = r[DW-1:0];
        e_cc = 3'($urandom);
    endtask

    logic [DBW-1:0] held_d;
    logic [WBW-1:0] held_w;

    initial begin
        exp_F = 'x; exp_D = 'x; exp_E = 'x; exp_M = 'x; exp_W = 'x; exp_CC = 'x; exp_err = 'x;

        // Reset with every other input forced high.
        rst_n = 1'b0; F_stall = 1; D_stall = 1; D_bubble = 1; E_bubble = 1;
        M_bubble = 1; W_stall = 1; set_CC = 1;
        f_predPC = '1; d_bus = '1; e_bus = '1; m_bus = '1; w_bus = '1; e_cc = '1;
        step("reset");
        chk("reset.D_const", 256'(D_bus), 256'({3'd1, 4'd1, 4'd0, 4'hF, 4'hF, 128'd0}));
        chk("reset.CC_const", 256'(CC), 256'(3'b100));

        // Normal flow.
        idle_ctrl();
        rand_data();
        d_bus = mk_d(3'd1, 4'd3, 4'd0, 4'd15, 4'd2, 64'h1234, 64'h0A);
        f_predPC = 64'h0A;
        step("normal");
        chk("normal.D_const", 256'(D_bus), 256'(mk_d(3'd1, 4'd3, 4'd0, 4'd15, 4'd2, 64'h1234, 64'h0A)));
        chk("normal.F_const", 256'(F_predPC), 256'(64'h0A));

        // Load-use stall.
        held_d = D_bus;
        rand_data();
        F_stall = 1; D_stall = 1; E_bubble = 1;
        step("loaduse");
        chk("loaduse.F_held", 256'(F_predPC), 256'(64'h0A));
        chk("loaduse.D_held", 256'(D_bus), 256'(held_d));
        chk("loaduse.err", 256'(ctrl_err), 256'(1'b0));

        // Mispredict.
        idle_ctrl();
        rand_data();
        d_bus = mk_d(3'd1, 4'd6, 4'd1, 4'd3, 4'd4, 64'h55, 64'h66);
        e_bus = mk_e(3'd1, 4'd6, 4'd1, 64'h1, 64'h2, 64'h3, 4'd3, 4'd15, 4'd3, 4'd4);
        D_bubble = 1; E_bubble = 1;
        step("mispredict");

        // Exception: preload W, then hold it while M bubbles.
        idle_ctrl();
        rand_data();
        step("preload");
        held_w = W_bus;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            w_bus = mk_w(3'd2, 4'd5, 64'h77, 64'h88, 4'd1, 4'd2);
            M_bubble = 1; W_stall = 1;
            step("exception");
            chk("exception.W_held", 256'(W_bus), 256'(held_w));
            chk("exception.M_bub", 256'(M_bus), 256'(bub_m()));
        end

        // Condition codes.
        idle_ctrl();
        rand_data();
        set_CC = 1; e_cc = 3'b010;
        step("cc_set");
        rand_data();
        set_CC = 0; e_cc = 3'b001;
        step("cc_hold");
        chk("cc_hold.const", 256'(CC), 256'(3'b010));

        // Illegal stall+bubble in D.
        held_d = D_bus;
        rand_data();
        D_stall = 1; D_bubble = 1;
        step("illegal");
        chk("illegal.D_held", 256'(D_bus), 256'(held_d));
        chk("illegal.err", 256'(ctrl_err), 256'(1'b1));

        // Randomized traffic; occasional reset, legal-and-illegal control mixes.
        for (int n = 0; n < 400; n++) begin
            rand_data();
            rst_n    = ($urandom_range(0, 31) != 0);
            F_stall  = ($urandom_range(0, 3) == 0);
            D_stall  = ($urandom_range(0, 3) == 0);
            D_bubble = ($urandom_range(0, 3) == 0);
            E_bubble = ($urandom_range(0, 3) == 0);
            M_bubble = ($urandom_range(0, 3) == 0);
            W_stall  = ($urandom_range(0, 3) == 0);
            set_CC   = ($urandom_range(0, 1) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
